// File: rtl/mbox_pkg.sv
// Shared constants for the HW/SW mailbox: control/status bit indices and the
// RX presenter state encoding.
package mbox_pkg;

    localparam int unsigned SIG_W      = 8;

    // sw_sig_in bit positions
    localparam int unsigned CI_PUSH    = 0;
    localparam int unsigned CI_POP     = 1;
    localparam int unsigned CI_LOOP    = 6;
    localparam int unsigned CI_CLR     = 7;

    // sw_sig_out bit positions
    localparam int unsigned SO_ACK     = 0;
    localparam int unsigned SO_NEW     = 1;
    localparam int unsigned SO_TXFULL  = 2;
    localparam int unsigned SO_RXEMPTY = 3;
    localparam int unsigned SO_ERR     = 5;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_SHOW = 1'b1
    } rx_state_e;

endpackage

// File: rtl/hw_sw_mailbox_if.sv
// Hardware-side stream pair of the mailbox: TX toward hardware, RX from it.
// master = mailbox side, slave = hardware side.
interface hw_sw_mailbox_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] hw_tx_data;
    logic              hw_tx_valid;
    logic              hw_tx_ready;
    logic [DATA_W-1:0] hw_rx_data;
    logic              hw_rx_valid;
    logic              hw_rx_ready;

    modport master (
        output hw_tx_data, hw_tx_valid, hw_rx_ready,
        input  hw_tx_ready, hw_rx_data, hw_rx_valid
    );

    modport slave (
        input  hw_tx_data, hw_tx_valid, hw_rx_ready,
        output hw_tx_ready, hw_rx_data, hw_rx_valid
    );
endinterface

// File: rtl/mbox_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers for full/empty.
// A write while full is accepted only together with a read.
module mbox_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic              w_wr_en;
    logic              w_rd_en;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign o_rdata = r_mem[r_rp[AW-1:0]];
    assign w_rd_en = i_rd && !o_empty;
    assign w_wr_en = i_wr && (!o_full || w_rd_en);

    // Pointer advance; wrap bit distinguishes full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr_en) r_wp <= r_wp + PW'(1);
            if (w_rd_en) r_rp <= r_rp + PW'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wp[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/hw_sw_mailbox.sv
// HW/SW mailbox: software pushes words by toggling a control bit, hardware
// drains them from a TX FIFO; hardware words land in an RX FIFO and are
// presented one at a time to software, advanced by a pop toggle.
// Optional feature macro: MBOX_LOOPBACK_EN (sw_sig_in[6] routes TX into RX).
module hw_sw_mailbox
    import mbox_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [DATA_W-1:0]  sw_data_in,
    input  logic [SIG_W-1:0]   sw_sig_in,
    output logic [DATA_W-1:0]  sw_data_out,
    output logic [SIG_W-1:0]   sw_sig_out,
    hw_sw_mailbox_if.master    hw
);
    logic              r_armed;
    logic [1:0]        r_sig_q;
    logic              r_pend;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_ack;
    logic              r_new;
    logic              r_err;
    logic [DATA_W-1:0] r_data_out;
    rx_state_e         r_state;
    rx_state_e         w_state_nxt;

    logic              w_push_tgl;
    logic              w_pop_tgl;
    logic              w_push_err;
    logic              w_pop_err;
    logic              w_load;
    logic              w_tx_wr;
    logic [DATA_W-1:0] w_tx_wdata;
    logic              w_tx_rd;
    logic [DATA_W-1:0] w_tx_head;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_rx_wr;
    logic [DATA_W-1:0] w_rx_wdata;
    logic              w_rx_rd;
    logic [DATA_W-1:0] w_rx_head;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_unused;

    // Toggles only count once the input copy has been loaded after reset
    assign w_push_tgl = r_armed && (sw_sig_in[CI_PUSH] != r_sig_q[0]);
    assign w_pop_tgl  = r_armed && (sw_sig_in[CI_POP]  != r_sig_q[1]);
    assign w_push_err = w_push_tgl && r_pend;
    assign w_tx_wr    = !w_tx_full && (r_pend || w_push_tgl);
    assign w_tx_wdata = r_pend ? r_pend_data : sw_data_in;

    // Input copy for toggle detection; first cycle out of reset just loads it
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_armed <= 1'b0;
            r_sig_q <= '0;
        end else begin
            r_armed <= 1'b1;
            r_sig_q <= sw_sig_in[1:0];
        end
    end

    // Pending push register and push-ack toggle
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_ack       <= 1'b0;
        end else if (w_tx_wr) begin
            r_pend <= 1'b0;
            r_ack  <= ~r_ack;
        end else if (w_push_tgl && !r_pend) begin
            r_pend      <= 1'b1;
            r_pend_data <= sw_data_in;
        end
    end

`ifdef MBOX_LOOPBACK_EN
    logic w_lb;
    logic w_lb_mv;

    // Loopback steals both streams from hardware and moves TX head into RX
    assign w_lb            = sw_sig_in[CI_LOOP];
    assign w_lb_mv         = w_lb && r_armed && !w_tx_empty && !w_rx_full;
    assign hw.hw_tx_valid  = r_armed && !w_tx_empty && !w_lb;
    assign hw.hw_rx_ready  = r_armed && !w_rx_full && !w_lb;
    assign w_tx_rd         = w_lb_mv || (hw.hw_tx_valid && hw.hw_tx_ready);
    assign w_rx_wr         = w_lb_mv || (hw.hw_rx_valid && hw.hw_rx_ready);
    assign w_rx_wdata      = w_lb ? w_tx_head : hw.hw_rx_data;
    assign w_unused        = ^{1'b0, sw_sig_in[5:2]};
`else
    // Plain stream connection to hardware
    assign hw.hw_tx_valid  = r_armed && !w_tx_empty;
    assign hw.hw_rx_ready  = r_armed && !w_rx_full;
    assign w_tx_rd         = hw.hw_tx_valid && hw.hw_tx_ready;
    assign w_rx_wr         = hw.hw_rx_valid && hw.hw_rx_ready;
    assign w_rx_wdata      = hw.hw_rx_data;
    assign w_unused        = ^{1'b0, sw_sig_in[6:2]};
`endif
    assign hw.hw_tx_data   = hw.hw_tx_valid ? w_tx_head : '0;

    mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_wr    (w_tx_wr),
        .i_wdata (w_tx_wdata),
        .i_rd    (w_tx_rd),
        .o_rdata (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_wr    (w_rx_wr),
        .i_wdata (w_rx_wdata),
        .i_rd    (w_rx_rd),
        .o_rdata (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // RX presenter state register
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) r_state <= RX_IDLE;
        else             r_state <= w_state_nxt;
    end

    // RX presenter next state: load a head word, advance on pop toggle
    always_comb begin
        w_state_nxt = r_state;
        w_rx_rd     = 1'b0;
        w_load      = 1'b0;
        w_pop_err   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_pop_tgl) w_pop_err = 1'b1;
                if (!w_rx_empty) begin
                    w_state_nxt = RX_SHOW;
                    w_rx_rd     = 1'b1;
                    w_load      = 1'b1;
                end
            end
            RX_SHOW: begin
                if (w_pop_tgl) begin
                    if (!w_rx_empty) begin
                        w_rx_rd = 1'b1;
                        w_load  = 1'b1;
                    end else begin
                        w_state_nxt = RX_IDLE;
                    end
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    // Presented word and new-word toggle
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_data_out <= '0;
            r_new      <= 1'b0;
        end else if (w_load) begin
            r_data_out <= w_rx_head;
            r_new      <= ~r_new;
        end
    end

    // Error sticky; a set in the same cycle as clear wins
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)                  r_err <= 1'b0;
        else if (w_push_err || w_pop_err) r_err <= 1'b1;
        else if (sw_sig_in[CI_CLR])       r_err <= 1'b0;
    end

    assign sw_data_out = r_data_out;

    // Status word assembled from registered state
    always_comb begin
        sw_sig_out             = '0;
        sw_sig_out[SO_ACK]     = r_ack;
        sw_sig_out[SO_NEW]     = r_new;
        sw_sig_out[SO_TXFULL]  = w_tx_full;
        sw_sig_out[SO_RXEMPTY] = (r_state == RX_IDLE);
        sw_sig_out[SO_ERR]     = r_err;
    end

endmodule

// File: tb/tb_hw_sw_mailbox.sv
// Scoreboard bench for hw_sw_mailbox (DATA_W=16, DEPTH=8). Expected TX words
// and expected software-presented words are queued by the stimulus; a monitor
// pops them on each TX handshake and each new-word toggle.
// Define MBOX_LOOPBACK_EN for both RTL and bench to cover loopback.
`timescale 1ns/1ps
module tb_hw_sw_mailbox;

    localparam int unsigned DW = 16;
    localparam int unsigned DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] sw_data_in;
    logic [7:0]    sw_sig_in;
    logic [DW-1:0] sw_data_out;
    logic [7:0]    sw_sig_out;

    hw_sw_mailbox_if #(.DATA_W(DW)) hw ();

    hw_sw_mailbox #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .sw_data_in  (sw_data_in),
        .sw_sig_in   (sw_sig_in),
        .sw_data_out (sw_data_out),
        .sw_sig_out  (sw_sig_out),
        .hw          (hw)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] tx_q [$];
    logic [DW-1:0] sw_q [$];
    logic          exp_ack;
    logic          exp_new;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        sw_data_in   = d;
        sw_sig_in[0] = ~sw_sig_in[0];
        step();
    endtask

    // Monitor: compare TX handshakes and new-word presentations against queues
    initial begin : monitor
        logic prev_new;
        prev_new = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_new = sw_sig_out[1];
            end else begin
                if (hw.hw_tx_valid && hw.hw_tx_ready) begin
                    if (tx_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL tx_unexpected: got 0x%0h, expected no word", hw.hw_tx_data);
                    end else begin
                        check("tx_word", 32'(hw.hw_tx_data), 32'(tx_q.pop_front()));
                    end
                end
                if (sw_sig_out[1] != prev_new) begin
                    prev_new = sw_sig_out[1];
                    if (sw_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL sw_unexpected: got 0x%0h, expected no word", sw_data_out);
                    end else begin
                        check("sw_word", 32'(sw_data_out), 32'(sw_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stim
        sw_data_in        = '0;
        sw_sig_in         = '0;
        hw.hw_tx_ready    = 1'b0;
        hw.hw_rx_valid    = 1'b0;
        hw.hw_rx_data     = '0;
        exp_ack           = 1'b0;
        exp_new           = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_sig_out",   32'(sw_sig_out), 32'h08);
        check("rst_data_out",  32'(sw_data_out), 32'h0);
        check("rst_tx_valid",  32'(hw.hw_tx_valid), 32'h0);
        check("rst_rx_ready",  32'(hw.hw_rx_ready), 32'h0);
        check("rst_tx_data",   32'(hw.hw_tx_data), 32'h0);
        rst = 1'b0;
        step();
        step();
        check("rx_ready_up",   32'(hw.hw_rx_ready), 32'h1);

        // Single push with hardware ready
        hw.hw_tx_ready = 1'b1;
        tx_q.push_back(16'h1234);
        sw_data_in   = 16'h1234;
        sw_sig_in[0] = 1'b1;
        #1;
        check("ack_before_edge", 32'(sw_sig_out[0]), 32'h0);
        step();
        exp_ack = 1'b1;
        check("ack_after_push",  32'(sw_sig_out[0]), 32'(exp_ack));
        check("tx_valid_push",   32'(hw.hw_tx_valid), 32'h1);
        check("tx_data_push",    32'(hw.hw_tx_data), 32'h1234);
        step();
        step();
        check("tx_valid_drained", 32'(hw.hw_tx_valid), 32'h0);

        // Fill TX with hardware stalled, then overflow into the pending register
        hw.hw_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_q.push_back(16'h0100 + 16'(i));
            push(16'h0100 + 16'(i));
            exp_ack = ~exp_ack;
            check("ack_fill", 32'(sw_sig_out[0]), 32'(exp_ack));
        end
        check("tx_full_set", 32'(sw_sig_out[2]), 32'h1);
        tx_q.push_back(16'h0108);
        push(16'h0108);
        check("ack_held_full",  32'(sw_sig_out[0]), 32'(exp_ack));
        check("err_clear_pend", 32'(sw_sig_out[5]), 32'h0);
        push(16'h0BAD);
        check("err_double_push", 32'(sw_sig_out[5]), 32'h1);
        check("ack_double_push", 32'(sw_sig_out[0]), 32'(exp_ack));
        sw_sig_in[7] = 1'b1;
        step();
        sw_sig_in[7] = 1'b0;
        check("err_cleared_1", 32'(sw_sig_out[5]), 32'h0);
        hw.hw_tx_ready = 1'b1;
        step();
        hw.hw_tx_ready = 1'b0;
        check("ack_still_pending", 32'(sw_sig_out[0]), 32'(exp_ack));
        step();
        exp_ack = ~exp_ack;
        check("ack_after_hw_pop", 32'(sw_sig_out[0]), 32'(exp_ack));
        check("tx_full_refill",   32'(sw_sig_out[2]), 32'h1);
        hw.hw_tx_ready = 1'b1;
        for (int k = 0; k < 20 && hw.hw_tx_valid; k++) step();
        step();
        check("tx_drain_valid", 32'(hw.hw_tx_valid), 32'h0);
        check("tx_q_empty",     32'(tx_q.size()), 32'h0);
        check("tx_full_clear",  32'(sw_sig_out[2]), 32'h0);

        // Two words from hardware, presented one per pop toggle
        sw_q.push_back(16'hA5A5);
        sw_q.push_back(16'h5A5A);
        hw.hw_rx_valid = 1'b1;
        hw.hw_rx_data  = 16'hA5A5;
        step();
        hw.hw_rx_data  = 16'h5A5A;
        step();
        hw.hw_rx_valid = 1'b0;
        step();
        step();
        exp_new = ~exp_new;
        check("rx_first_word",  32'(sw_data_out), 32'hA5A5);
        check("rx_new_first",   32'(sw_sig_out[1]), 32'(exp_new));
        check("rx_not_empty",   32'(sw_sig_out[3]), 32'h0);
        sw_sig_in[1] = ~sw_sig_in[1];
        step();
        exp_new = ~exp_new;
        check("rx_second_word", 32'(sw_data_out), 32'h5A5A);
        check("rx_new_second",  32'(sw_sig_out[1]), 32'(exp_new));
        sw_sig_in[1] = ~sw_sig_in[1];
        step();
        step();
        check("rx_empty_after", 32'(sw_sig_out[3]), 32'h1);
        check("rx_new_held",    32'(sw_sig_out[1]), 32'(exp_new));
        check("rx_err_none",    32'(sw_sig_out[5]), 32'h0);
        check("sw_q_empty",     32'(sw_q.size()), 32'h0);

        // Pop toggle with nothing to show
        sw_sig_in[1] = ~sw_sig_in[1];
        step();
        check("err_pop_empty",  32'(sw_sig_out[5]), 32'h1);
        check("data_held",      32'(sw_data_out), 32'h5A5A);
        sw_sig_in[7] = 1'b1;
        step();
        sw_sig_in[7] = 1'b0;
        check("err_cleared_2",  32'(sw_sig_out[5]), 32'h0);

        // Reset with words in flight; no spurious toggles afterwards
        hw.hw_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(16'h0300 + 16'(i));
            exp_ack = ~exp_ack;
        end
        check("tx_valid_inflight", 32'(hw.hw_tx_valid), 32'h1);
        check("ack_inflight",      32'(sw_sig_out[0]), 32'(exp_ack));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", 32'(hw.hw_tx_valid), 32'h0);
        check("mid_rst_sig_out",  32'(sw_sig_out), 32'h08);
        check("mid_rst_data_out", 32'(sw_data_out), 32'h0);
        sw_sig_in[0] = ~sw_sig_in[0];
        step();
        step();
        rst = 1'b0;
        hw.hw_tx_ready = 1'b1;
        exp_ack = 1'b0;
        exp_new = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("post_rst_sig_out",  32'(sw_sig_out), 32'h08);
            check("post_rst_tx_valid", 32'(hw.hw_tx_valid), 32'h0);
        end

`ifdef MBOX_LOOPBACK_EN
        // Loopback: pushed word returns to software, hardware sees nothing
        sw_sig_in[6] = 1'b1;
        sw_q.push_back(16'h00FF);
        push(16'h00FF);
        exp_ack = ~exp_ack;
        check("lb_ack", 32'(sw_sig_out[0]), 32'(exp_ack));
        for (int k = 0; k < 4; k++) begin
            check("lb_tx_valid", 32'(hw.hw_tx_valid), 32'h0);
            step();
        end
        exp_new = ~exp_new;
        check("lb_data_out", 32'(sw_data_out), 32'h00FF);
        check("lb_new",      32'(sw_sig_out[1]), 32'(exp_new));
        check("lb_rx_ready", 32'(hw.hw_rx_ready), 32'h0);
        check("lb_sw_q",     32'(sw_q.size()), 32'h0);
        sw_sig_in[6] = 1'b0;
        step();
`endif

        step();
        check("final_tx_q", 32'(tx_q.size()), 32'h0);
        check("final_sw_q", 32'(sw_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hw_sw_mailbox.md
HW_SW_MAILBOX -- requirements
Module: hw_sw_mailbox

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width of data paths (1..32).
REQ-002 SHALL have parameter DEPTH, default 8, entries per FIFO; power of two, >=2.
REQ-003 SHALL have port clk_clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sw_data_in  input  DATA_W  word from software PIO (to_hw_port).
REQ-006 SHALL have port sw_sig_in  input  8  software control: [0] push toggle, [1] pop toggle, [6] loopback select, [7] clear-sticky level.
REQ-007 SHALL have port sw_data_out  output  DATA_W  word presented to software PIO (to_sw_port).
REQ-008 SHALL have port sw_sig_out  output  8  status: [0] push-ack toggle, [1] new-word toggle, [2] tx_full, [3] rx_empty, [5] error sticky, [4],[7:6] zero.
REQ-009 SHALL have ports hw_tx_data  output  DATA_W, hw_tx_valid  output  1, hw_tx_ready  input  1  stream to hardware.
REQ-010 SHALL have ports hw_rx_data  input  DATA_W, hw_rx_valid  input  1, hw_rx_ready  output  1  stream from hardware.

Function
REQ-011 SHALL register sw_sig_in[1:0] each cycle; a toggle is a difference between input and registered copy.
REQ-012 SHALL, on push toggle, capture sw_data_in into a pending register; the word is written to TX FIFO at the first edge with TX not full (same edge if space), and sw_sig_out[0] flips at that edge.
REQ-013 SHALL set error sticky and ignore the toggle when a push toggle arrives while a push is still pending.
REQ-014 SHALL drive hw_tx_valid = TX not empty, hw_tx_data = TX head (first-word fall-through); pop on valid&ready.
REQ-015 SHALL drive hw_rx_ready = RX not full; write RX on valid&ready.
REQ-016 SHALL run an RX presenter FSM with states RX_IDLE and RX_SHOW: IDLE->SHOW when RX non-empty (load head into sw_data_out, pop FIFO, flip sw_sig_out[1]); SHOW + pop toggle -> reload next head and flip [1] if RX non-empty, else -> IDLE.
REQ-017 SHALL set error sticky and hold sw_data_out on a pop toggle in RX_IDLE.
REQ-018 SHALL drive sw_sig_out[2] = TX full, [3] = presenter in RX_IDLE, both registered.
REQ-019 SHALL clear error sticky while sw_sig_in[7]=1; a same-cycle set wins.
REQ-020 SHALL wrap FIFO pointers modulo DEPTH using log2(DEPTH)+1-bit pointers for full/empty; simultaneous read and write when full or empty SHALL be legal and keep count correct.

Reset
REQ-021 SHALL on reset clear all outputs to 0 except sw_sig_out[3]=1, empty both FIFOs, drop pending push, FSM to RX_IDLE.
REQ-022 SHALL on the first cycle after reset release load the sw_sig_in copy without acting on any difference.
REQ-023 SHALL discard in-flight words when reset asserts mid-operation.

Configuration
REQ-024 With MBOX_LOOPBACK_EN defined, sw_sig_in[6]=1 SHALL route TX head into RX FIFO (hw_tx_valid=0, hw_rx_ready=0); without it sw_sig_in[6] SHALL be ignored and no loopback logic exist.

Structure
REQ-025 SHALL place status/control bit-index constants and RX FSM state enum in package mbox_pkg.
REQ-026 SHALL instantiate sub-module mbox_fifo (DATA_W, DEPTH; FWFT, full/empty) twice for TX and RX.

Verification
REQ-027 Push 0x1234 via [0] toggle, hw_tx_ready=1 -> ack toggles 1 cycle later, hw_tx_data=0x1234 with valid.
REQ-028 hw_tx_ready=0, 9 pushes at DEPTH=8 -> 8 acks, tx_full=1, 9th ack only after one hw pop.
REQ-029 hw_rx sends 0xA5A5,0x5A5A -> sw_data_out=0xA5A5, [1] toggles; pop toggle -> 0x5A5A, [1] toggles; pop -> rx_empty=1.
REQ-030 Pop toggle with RX empty -> error=1; sw_sig_in[7]=1 one cycle -> error=0.
REQ-031 MBOX_LOOPBACK_EN, [6]=1, push 0x00FF -> sw_data_out=0x00FF, hw_tx_valid stays 0.
REQ-032 Reset asserted with 3 words in TX -> hw_tx_valid=0, acks 0, no spurious toggle after release.
